// File: rtl/mips_mem_if.sv
// Avalon-MM style word bus between the mips_cpu (master) and a memory responder (slave).
// Handshake: a request (read or write) is accepted on the rising edge where it is presented and
// waitrequest is low; while waitrequest is high the master holds address/read/write/byteenable/writedata.
interface mips_mem_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_mem_responder.sv
// Word-addressed RAM answering the mips_cpu bus with programmable wait states.
// Optional macro MEM_RESPONDER_RANDOM_WAIT_EN: per-transfer wait count drawn from a 16-bit Galois LFSR.
module mips_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic       clk,
  input  logic       reset,
  mips_mem_if.slave  bus,
  output logic       o_dbg_state
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_MAX = 4'(WAIT_CYCLES);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_readdata;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic [31:0] r_lat_addr;
  logic        r_lat_rd;
  logic        r_lat_wr;
  logic [3:0]  r_lat_be;

  logic [31:0] w_offset;
  logic        w_in_range;
  logic [AW-1:0] w_idx;
  logic        w_req;
  logic        w_match;
  logic        w_accept;
  logic        w_latch;
  logic        w_waitrequest;
  logic [3:0]  w_new_wait;
  logic [3:0]  w_wait_tgt;

  // Subtracting first makes addresses below BASE_ADDR wrap to huge offsets, so one compare covers both ends.
  assign w_offset   = bus.address - BASE_ADDR;
  assign w_in_range = (w_offset < SPAN);
  assign w_idx      = w_offset[AW+1:2];
  assign w_req      = bus.read ^ bus.write;
  assign w_match    = (bus.address == r_lat_addr) && (bus.read == r_lat_rd) &&
                      (bus.write == r_lat_wr) && (bus.byteenable == r_lat_be);

`ifdef MEM_RESPONDER_RANDOM_WAIT_EN
  logic [15:0] r_lfsr;
  logic [3:0]  r_wait_tgt;

  assign w_new_wait = 4'({1'b0, r_lfsr[3:0]} % 5'(WAIT_CYCLES + 1));
  assign w_wait_tgt = r_wait_tgt;

  // Right-shifting Galois form of taps 16,14,13,11; steps once per accepted transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr     <= 16'hACE1;
      r_wait_tgt <= 4'd0;
    end else begin
      if (w_accept) r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
      if (w_latch)  r_wait_tgt <= w_new_wait;
    end
  end
`else
  assign w_new_wait = WAIT_MAX;
  assign w_wait_tgt = WAIT_MAX;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_accept      = 1'b0;
    w_latch       = 1'b0;
    w_waitrequest = 1'b0;
    if (reset) begin
      w_waitrequest = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_new_wait == 4'd0) begin
              w_accept = 1'b1;
            end else begin
              w_waitrequest = 1'b1;
              w_latch       = 1'b1;
              w_cnt_nxt     = 4'd1;
              w_state_nxt   = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // A changed request abandons the old one; a valid new one is held off and restarts from IDLE.
          if (!w_match) begin
            w_waitrequest = w_req;
            w_cnt_nxt     = 4'd0;
            w_state_nxt   = S_IDLE;
          end else if (r_cnt >= w_wait_tgt) begin
            w_accept    = 1'b1;
            w_cnt_nxt   = 4'd0;
            w_state_nxt = S_IDLE;
          end else begin
            w_waitrequest = 1'b1;
            w_cnt_nxt     = 4'(r_cnt + 4'd1);
          end
        end
        default: begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_readdata <= 32'h0;
      r_lat_addr <= 32'h0;
      r_lat_rd   <= 1'b0;
      r_lat_wr   <= 1'b0;
      r_lat_be   <= 4'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) begin
        r_lat_addr <= bus.address;
        r_lat_rd   <= bus.read;
        r_lat_wr   <= bus.write;
        r_lat_be   <= bus.byteenable;
      end
      if (w_accept && bus.read) begin
        r_readdata <= w_in_range ? r_mem[w_idx] : 32'h0;
      end
    end
  end

  // Memory has no reset: contents survive a reset of the handshake logic.
  always_ff @(posedge clk) begin
    if (w_accept && bus.write && w_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.byteenable[i]) r_mem[w_idx][8*i +: 8] <= bus.writedata[8*i +: 8];
      end
    end
  end

  assign bus.waitrequest = w_waitrequest;
  assign bus.readdata    = r_readdata;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder: a 2-wait-state instance and a zero-wait instance.
module tb_mips_mem_responder;

  localparam logic [31:0] BASE  = 32'hBFC0_0000;
  localparam int          DEPTH = 1024;

  logic clk;
  logic reset;
  logic dbg2;
  logic dbg0;

  mips_mem_if bus2 ();
  mips_mem_if bus0 ();

  mips_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave), .o_dbg_state(dbg2)
  );

  mips_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave), .o_dbg_state(dbg0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic idle2();
    bus2.read = 1'b0; bus2.write = 1'b0; bus2.address = 32'h0;
    bus2.byteenable = 4'h0; bus2.writedata = 32'h0;
  endtask

  task automatic idle0();
    bus0.read = 1'b0; bus0.write = 1'b0; bus0.address = 32'h0;
    bus0.byteenable = 4'h0; bus0.writedata = 32'h0;
  endtask

  task automatic drive2(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] data);
    bus2.read = rd; bus2.write = wr; bus2.address = addr;
    bus2.byteenable = be; bus2.writedata = data;
  endtask

  // Called at a negedge with a request already presented; returns at the negedge where it is accepted.
  task automatic wait_accept2(output int waits, output bit ok);
    waits = 0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (!bus2.waitrequest) begin
        ok = 1'b1;
        break;
      end
      waits++;
      @(negedge clk);
    end
  endtask

  task automatic do_xfer2(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] data,
                          output int waits, output bit ok, output logic [31:0] rdata);
    @(posedge clk); #1;
    drive2(rd, wr, addr, be, data);
    @(negedge clk);
    wait_accept2(waits, ok);
    @(posedge clk); #1;
    idle2();
    @(negedge clk);
    rdata = bus2.readdata;
  endtask

  typedef struct {
    string       name;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          exp_waits;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int          waits;
    bit          ok;
    logic [31:0] rdata;
    logic [31:0] vals[4];

    reset = 1'b1;
    idle2();
    idle0();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_waitreq_w2", 32'(bus2.waitrequest), 32'd1);
    check("reset_waitreq_w0", 32'(bus0.waitrequest), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_rdata_w2", bus2.readdata, 32'h0);
    check("reset_rdata_w0", bus0.readdata, 32'h0);
    check("idle_waitreq_w2", 32'(bus2.waitrequest), 32'd0);
    check("reset_state_w2", 32'(dbg2), 32'd0);

    vecs.push_back('{"wr_deadbeef",   1'b0, 1'b1, BASE + 32'd8,    4'hF, 32'hDEADBEEF, 2, 32'h0});
    vecs.push_back('{"rd_deadbeef",   1'b1, 1'b0, BASE + 32'd8,    4'hF, 32'h0,        2, 32'hDEADBEEF});
    vecs.push_back('{"wr_word0",      1'b0, 1'b1, BASE,            4'hF, 32'h01020304, 2, 32'h0});
    vecs.push_back('{"wr_word3_full", 1'b0, 1'b1, BASE + 32'd12,   4'hF, 32'h11223344, 2, 32'h0});
    vecs.push_back('{"wr_word3_0101", 1'b0, 1'b1, BASE + 32'd12,   4'b0101, 32'hAABBCCDD, 2, 32'h0});
    vecs.push_back('{"rd_merged",     1'b1, 1'b0, BASE + 32'd12,   4'h0, 32'h0,        2, 32'h11BB33DD});
    vecs.push_back('{"rd_below_base", 1'b1, 1'b0, BASE - 32'd4,    4'hF, 32'h0,        2, 32'h0});
    vecs.push_back('{"rd_word0",      1'b1, 1'b0, BASE,            4'hF, 32'h0,        2, 32'h01020304});
    vecs.push_back('{"rd_past_end",   1'b1, 1'b0, BASE + 32'd4096, 4'hF, 32'h0,        2, 32'h0});
    vecs.push_back('{"wr_below_base", 1'b0, 1'b1, BASE - 32'd4,    4'hF, 32'hFFFFFFFF, 2, 32'h0});
    vecs.push_back('{"wr_past_end",   1'b0, 1'b1, BASE + 32'd4096, 4'hF, 32'hFFFFFFFF, 2, 32'h0});
    vecs.push_back('{"rd_word0_kept", 1'b1, 1'b0, BASE,            4'hF, 32'h0,        2, 32'h01020304});
    vecs.push_back('{"rd_word2_kept", 1'b1, 1'b0, BASE + 32'd8,    4'hF, 32'h0,        2, 32'hDEADBEEF});
    vecs.push_back('{"rd_word3_kept", 1'b1, 1'b0, BASE + 32'd12,   4'hF, 32'h0,        2, 32'h11BB33DD});
    vecs.push_back('{"wr_last_full",  1'b0, 1'b1, BASE + 32'd4092, 4'hF, 32'h00000000, 2, 32'h0});
    vecs.push_back('{"wr_last_hi",    1'b0, 1'b1, BASE + 32'd4092, 4'b1100, 32'hCAFEF00D, 2, 32'h0});
    vecs.push_back('{"rd_last",       1'b1, 1'b0, BASE + 32'd4095, 4'h1, 32'h0,        2, 32'hCAFE0000});

    foreach (vecs[i]) begin
      do_xfer2(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wdata, waits, ok, rdata);
      check({vecs[i].name, "_accepted"}, 32'(ok), 32'd1);
      check({vecs[i].name, "_waits"}, 32'(waits), 32'(vecs[i].exp_waits));
      if (vecs[i].rd) check({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
    end

    // Reset in the first WAIT cycle while a read is held; the read then restarts from IDLE.
    @(posedge clk); #1;
    drive2(1'b1, 1'b0, BASE + 32'd8, 4'hF, 32'h0);
    @(negedge clk);
    check("rst_seq_first_waitreq", 32'(bus2.waitrequest), 32'd1);
    @(posedge clk); #1;
    check("rst_seq_in_wait", 32'(dbg2), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_seq_waitreq_in_reset", 32'(bus2.waitrequest), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_seq_rdata_cleared", bus2.readdata, 32'h0);
    wait_accept2(waits, ok);
    check("rst_seq_accepted", 32'(ok), 32'd1);
    check("rst_seq_waits", 32'(waits), 32'd2);
    @(posedge clk); #1;
    idle2();
    @(negedge clk);
    check("rst_seq_rdata", bus2.readdata, 32'hDEADBEEF);

    // Illegal read+write: no wait, no access, readdata held.
    @(posedge clk); #1;
    drive2(1'b1, 1'b1, BASE + 32'd12, 4'hF, 32'h0);
    @(negedge clk);
    check("rw_both_waitreq", 32'(bus2.waitrequest), 32'd0);
    @(posedge clk); #1;
    idle2();
    @(negedge clk);
    check("rw_both_rdata_held", bus2.readdata, 32'hDEADBEEF);
    do_xfer2(1'b1, 1'b0, BASE + 32'd12, 4'hF, 32'h0, waits, ok, rdata);
    check("rw_both_mem_kept", rdata, 32'h11BB33DD);

    // Address changes mid-wait: old request abandoned, new one pays the full wait afresh.
    @(posedge clk); #1;
    drive2(1'b1, 1'b0, BASE + 32'd12, 4'hF, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    bus2.address = BASE + 32'd8;
    @(negedge clk);
    wait_accept2(waits, ok);
    check("abandon_accepted", 32'(ok), 32'd1);
    check("abandon_waits", 32'(waits), 32'd3);
    @(posedge clk); #1;
    idle2();
    @(negedge clk);
    check("abandon_rdata", bus2.readdata, 32'hDEADBEEF);

    // Zero-wait instance: writes then four back-to-back reads.
    vals[0] = 32'h01234567;
    vals[1] = 32'h89ABCDEF;
    vals[2] = 32'h13579BDF;
    vals[3] = 32'h2468ACE0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus0.read = 1'b0; bus0.write = 1'b1; bus0.address = BASE + 32'(4 * i);
      bus0.byteenable = 4'hF; bus0.writedata = vals[i];
      @(negedge clk);
      check($sformatf("w0_write%0d_waitreq", i), 32'(bus0.waitrequest), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus0.write = 1'b0; bus0.read = 1'b1; bus0.address = BASE + 32'(4 * i);
      bus0.writedata = 32'h0;
      @(negedge clk);
      check($sformatf("w0_read%0d_waitreq", i), 32'(bus0.waitrequest), 32'd0);
      if (i > 0) check($sformatf("w0_rdata%0d", i - 1), bus0.readdata, vals[i-1]);
    end
    @(posedge clk); #1;
    idle0();
    @(negedge clk);
    check("w0_rdata3", bus0.readdata, vals[3]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
